// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS EX stage.
// The result is computed at the start edge; the counter only paces the pipeline-visible latency.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mt_we,
  input  logic        hl_sel,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] hl_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   res_q, res_d;
  logic          nowr_q, nowr_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [63:0]        mul_s, mul_u, result;
  logic [31:0]        div_b, sdiv_b, uq, ur;
  logic signed [31:0] sq, sr;
  logic               ovf;

  // Divisor is forced to 1 for b=0 (result discarded) and for the
  // 0x80000000 / -1 overflow, which yields exactly LO=0x80000000, HI=0.
  always_comb begin
    mul_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mul_u  = {32'd0, a} * {32'd0, b};
    ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    div_b  = (b == 32'd0) ? 32'd1 : b;
    sdiv_b = ovf ? 32'd1 : div_b;
    sq     = $signed(a) / $signed(sdiv_b);
    sr     = $signed(a) % $signed(sdiv_b);
    uq     = a / div_b;
    ur     = a % div_b;
    case (op)
      2'b00:   result = mul_s;
      2'b01:   result = mul_u;
      2'b10:   result = {sr, sq};
      default: result = {ur, uq};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    nowr_d  = nowr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          res_d   = result;
          nowr_d  = op[1] && (b == 32'd0);
          cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = RUN;
        end else if (mt_we) begin
          if (hl_sel) hi_d = mt_data;
          else        lo_d = mt_data;
        end
      end
      default: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (!nowr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      nowr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      nowr_q  <= nowr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign md_hazard = start | busy;
  assign hl_out    = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, hand-written corner sequences,
// and randomized ops against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, mt_we, hl_sel;
  logic [1:0]  op;
  logic [31:0] a, b, mt_data;
  logic        busy, md_hazard;
  logic [31:0] hl_out;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mt_we(mt_we), .hl_sel(hl_sel), .mt_data(mt_data),
    .busy(busy), .md_hazard(md_hazard), .hl_out(hl_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    hl_sel = 1'b1; #1; hi = hl_out;
    hl_sel = 1'b0; #1; lo = hl_out;
  endtask

  // Reference: whole 64-bit arithmetic on sign/zero-extended operands.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x);          uy = longint'(y);
    case (o)
      2'b00: begin p = longint'(sx * sy); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = ux * uy;           hi = p[63:32]; lo = p[31:0]; end
      2'b10: if (y != 0) begin q = sx / sy; r = sx % sy; hi = r[31:0]; lo = q[31:0]; end
      default: if (y != 0) begin hi = 32'(ux % uy); lo = 32'(ux / uy); end
    endcase
  endfunction

  task automatic mt_write(input logic sel, input logic [31:0] d);
    hl_sel = sel; mt_we = 1'b1; mt_data = d;
    tick();
    mt_we = 1'b0;
    if (sel) m_hi = d; else m_lo = d;
  endtask

  // inject: 0 none, 1 second start during busy, 2 mt_we during busy, 3 mt_we with the start
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int inject);
    int n;
    bit haz_ok;
    logic [31:0] hi, lo;
    op = o; a = x; b = y; start = 1'b1;
    if (inject == 3) begin mt_we = 1'b1; hl_sel = 1'b0; mt_data = 32'hBAD0_BAD0; end
    #1;
    haz_ok = md_hazard;
    tick();
    start = 1'b0; mt_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    ref_op(o, x, y, m_hi, m_lo);
    n = 0;
    while (busy && n < 200) begin
      n++;
      haz_ok &= md_hazard;
      if (n == 2 && inject == 1) begin start = 1'b1; a = 32'h7; b = 32'h3; end
      if (n == 2 && inject == 2) begin mt_we = 1'b1; hl_sel = $urandom; mt_data = 32'hDEAD_BEEF; end
      tick();
      start = 1'b0; mt_we = 1'b0;
    end
    chk({name, " busy_cycles"}, 64'(n), o[1] ? 64'(DC) : 64'(MC));
    chk({name, " md_hazard"}, 64'(haz_ok), 64'd1);
    read_hl(hi, lo);
    chk({name, " hi_lo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] hi, lo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    vecs.push_back('{2'b00, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'h7,         32'h2,         32'h1,         32'h3});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF});
    vecs.push_back('{2'b10, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD});

    reset = 1'b1; start = 1'b0; mt_we = 1'b0; hl_sel = 1'b0; op = 2'b00;
    a = 0; b = 0; mt_data = 0;
    tick(); tick();
    reset = 1'b0;
    read_hl(hi, lo);
    chk("reset hi_lo", {hi, lo}, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset hazard", 64'(md_hazard), 64'd0);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0);
      chk($sformatf("vec%0d table", i), {m_hi, m_lo}, {vecs[i].hi, vecs[i].lo});
    end

    mt_write(1'b1, 32'h1234);
    mt_write(1'b0, 32'h5678);
    read_hl(hi, lo);
    chk("mt write", {hi, lo}, {32'h1234, 32'h5678});
    run_op("div0", 2'b10, 32'd99, 32'd0, 0);
    chk("div0 kept", {m_hi, m_lo}, {32'h1234, 32'h5678});
    run_op("divu0 with mt", 2'b11, 32'd5, 32'd0, 3);
    chk("start beats mt", {m_hi, m_lo}, {32'h1234, 32'h5678});

    run_op("restart ignored", 2'b00, 32'd1000, 32'd3000, 1);
    run_op("mt during busy", 2'b11, 32'd100, 32'd7, 2);

    // reset in the third busy cycle of a mult
    op = 2'b00; a = 32'h55; b = 32'h66; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    chk("midop reset busy", 64'(busy), 64'd0);
    read_hl(hi, lo);
    chk("midop reset hi_lo", {hi, lo}, 64'd0);
    repeat (6) tick();
    read_hl(hi, lo);
    chk("stays idle", {hi, lo, 31'd0, busy}, 96'd0);
    run_op("after reset", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom); ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 5));
      run_op($sformatf("rand%0d", i), ro, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the 5-stage pipelined MIPS core.
- Executes mult, multu, div and divu.
- Owns the HI/LO registers, services mthi/mtlo writes and drives the read value for mfhi/mflo.
- Exports busy/stall information to the hazard logic so that later HI/LO instructions are held in ID.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse from EX: begin operation op on operands a, b.
- op  input  2  operation code: 00 mult, 01 multu, 10 div, 11 divu.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- mt_we  input  1  mthi/mtlo write enable.
- hl_sel  input  1  0 selects LO, 1 selects HI; used for both the mt write and the mf read.
- mt_data  input  32  data written by mthi/mtlo.
- busy  output  1  high while an operation is in progress.
- md_hazard  output  1  combinational start | busy; the hazard unit stalls any HI/LO-class instruction in ID while this is high.
- hl_out  output  32  combinational read: HI when hl_sel=1, LO when hl_sel=0.

Behaviour:
- Reset (synchronous, checked before anything else):
  - HI=0, LO=0, busy=0, internal counter=0, latched result=0.
  - Reset mid-operation aborts the operation; HI/LO stay 0 afterwards.
- State machine has two states, IDLE and RUN.
- IDLE with start=1 at edge E0:
  - Latch op, a and b, and compute the full result.
  - Load counter with MULT_CYCLES for op 00/01, or DIV_CYCLES for op 10/11.
  - Go to RUN; busy=1 from the cycle after E0.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter reaches 0, write the result into HI/LO, set busy=0 and return to IDLE.
  - busy is therefore high for exactly N cycles. The first cycle with busy=0 shows the new HI/LO on hl_out.
- Multiply: the 64-bit product goes {HI,LO}.
  - mult: signed × signed.
  - multu: unsigned × unsigned.
- Divide: LO=quotient, HI=remainder.
  - div: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
  - Special case, div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (b=0, div or divu): the operation still runs DIV_CYCLES with busy asserted, but HI and LO are left unchanged at completion.
- start while busy=1: ignored; the in-flight operation is unaffected.
- mt_we:
  - When idle and start=0: at the edge, HI<=mt_data if hl_sel=1, else LO<=mt_data.
  - While busy=1: ignored.
  - If mt_we and start are both high in the same idle cycle, start wins and the mt write is dropped.
- hl_out is purely combinational from the current HI/LO registers; it is not bypassed from mt_data or from an in-flight result.
- Operands are sampled only at the start edge; later changes on a and b have no effect.

Test Plan:
- mult: reset, then start op=00, a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu and operand hold: start op=01, a=0xFFFFFFFF, b=2, then change a to 0 the next cycle → after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div and divu:
  - op=10, a=-7 (0xFFFFFFF9), b=2 → 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - op=11, a=7, b=2 → LO=3, HI=1.
  - op=10, a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x1234, LO=0x5678 via mt_we, then div with b=0 → busy 10 cycles; HI/LO remain 0x1234/0x5678.
- Conflicts:
  - start pulsed again during busy → ignored; result and completion cycle match the first op.
  - mt_we during busy → HI/LO unchanged.
  - start and mt_we in the same cycle → mt write dropped.
  - md_hazard high during the start cycle and all busy cycles.
- Reset mid-op: reset in cycle 3 of a mult → next cycle busy=0, HI=LO=0; the unit stays idle and a fresh start then works normally.
